// File: rtl/drp_responder.sv
// DRP register-file responder: NUM_REGS R/W registers, a read-only status word
// at 0x1FF and a transaction counter at 0x1FE, answering after a fixed latency.
module drp_responder #(
   parameter int NUM_REGS = 32,
   parameter int LATENCY  = 3
) (
   input  logic                    drp_clk,
   input  logic                    rst,
   input  logic                    drpen_i,
   input  logic                    drpwe_i,
   input  logic [8:0]              drpaddr_i,
   input  logic [15:0]             drpdi_i,
   output logic                    drprdy_o,
   output logic [15:0]             drpdo_o,
   input  logic [15:0]             status_i,
   output logic [NUM_REGS*16-1:0]  reg_q_o,
   output logic [15:0]             access_cnt_o,
   output logic                    err_busy_o,
   output logic                    err_addr_o,
   output logic [1:0]              dbg_state_o
);

   // Handshake: drpen_i is accepted only in S_IDLE; exactly LATENCY cycles later
   // drprdy_o pulses for one cycle with drpdo_o valid; strobes while busy are dropped.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   localparam logic [3:0] WAIT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
   localparam logic [8:0] ADDR_CNT  = 9'h1FE;
   localparam logic [8:0] ADDR_STAT = 9'h1FF;

   state_t      state_q, state_d;
   logic [3:0]  wcnt_q, wcnt_d;
   logic [8:0]  addr_q, addr_d;
   logic        we_q, we_d;
   logic [15:0] di_q, di_d;
   logic [15:0] stat_q, stat_d;
   logic [15:0] access_cnt_q, access_cnt_d;
   logic        err_busy_q, err_busy_d;
   logic [15:0] regs_q [NUM_REGS];
   logic [15:0] regs_d [NUM_REGS];

   logic        is_reg;
   logic        is_unmapped;
   logic        ack;
   logic [15:0] reg_rd;
   logic [15:0] rd_data;

   always_comb begin
      is_reg      = (addr_q < 9'(NUM_REGS));
      is_unmapped = !is_reg && (addr_q != ADDR_CNT) && (addr_q != ADDR_STAT);
      reg_rd      = 16'h0000;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (addr_q == 9'(k)) reg_rd = regs_q[k];
      end
      if (addr_q == ADDR_STAT)     rd_data = stat_q;
      else if (addr_q == ADDR_CNT) rd_data = access_cnt_q;
      else if (is_reg)             rd_data = reg_rd;
      else                         rd_data = 16'hDEAD;
   end

   always_comb begin
      state_d      = state_q;
      wcnt_d       = wcnt_q;
      addr_d       = addr_q;
      we_d         = we_q;
      di_d         = di_q;
      stat_d       = stat_q;
      access_cnt_d = access_cnt_q;
      err_busy_d   = 1'b0;
      regs_d       = regs_q;
      case (state_q)
         S_IDLE: begin
            if (drpen_i) begin
               addr_d = drpaddr_i;
               we_d   = drpwe_i;
               di_d   = drpdi_i;
               stat_d = status_i;
               wcnt_d = WAIT_LOAD;
               state_d = (LATENCY == 1) ? S_ACK : S_WAIT;
            end
         end
         S_WAIT: begin
            err_busy_d = drpen_i;
            if (wcnt_q == 4'd0) state_d = S_ACK;
            else                wcnt_d  = wcnt_q - 4'd1;
         end
         S_ACK: begin
            err_busy_d = drpen_i;
            state_d    = S_IDLE;
            for (int k = 0; k < NUM_REGS; k++) begin
               if (we_q && (addr_q == 9'(k))) regs_d[k] = di_q;
            end
            // A write to the counter address clears it in place of the increment.
            if (we_q && (addr_q == ADDR_CNT))    access_cnt_d = 16'h0000;
            else if (access_cnt_q != 16'hFFFF) access_cnt_d = access_cnt_q + 16'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge drp_clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         wcnt_q       <= 4'd0;
         addr_q       <= 9'd0;
         we_q         <= 1'b0;
         di_q         <= 16'h0000;
         stat_q       <= 16'h0000;
         access_cnt_q <= 16'h0000;
         err_busy_q   <= 1'b0;
         for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= 16'h0000;
      end else begin
         state_q      <= state_d;
         wcnt_q       <= wcnt_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         di_q         <= di_d;
         stat_q       <= stat_d;
         access_cnt_q <= access_cnt_d;
         err_busy_q   <= err_busy_d;
         regs_q       <= regs_d;
      end
   end

   // Completion outputs are masked by rst so a reset landing on ACK shows nothing.
   always_comb begin
      ack          = (state_q == S_ACK) && !rst;
      drprdy_o     = ack;
      drpdo_o      = ack ? rd_data : 16'h0000;
      err_addr_o   = ack && is_unmapped;
      err_busy_o   = err_busy_q;
      access_cnt_o = access_cnt_q;
      dbg_state_o  = state_q;
      reg_q_o      = '0;
      for (int k = 0; k < NUM_REGS; k++) reg_q_o[16*k +: 16] = regs_q[k];
   end

endmodule
